// File: rtl/punti_pkg.sv
// Shared constants for the point transmitter: handshake FSM encoding,
// dav_ polarity and default coordinate width.
package punti_pkg;

    localparam int W_DEFAULT = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_VALID   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic DAV_ATTIVO   = 1'b0;
    localparam logic DAV_INATTIVO = 1'b1;

endpackage

// File: rtl/fifo_punti.sv
// Small FIFO of packed {x,y} words; head is readable combinationally so the
// transmitter can latch it on the same edge that pops it.
module fifo_punti
    import punti_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic [2*W-1:0] din,
    output logic [2*W-1:0] dout,
    output logic           full,
    output logic           empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/trasmettitore_punti.sv
// FIFO-fed source side of the four-phase dav_/rfd handshake: presents one
// (X,Y) point at a time and counts completed transfers.
module trasmettitore_punti
    import punti_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = 4,
    parameter int SYNC  = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    output logic         full,
    output logic         empty,
    output logic         overflow,
    output logic [7:0]   sent,
    input  logic         rfd,
    output logic         dav_,
    output logic [W-1:0] X,
    output logic [W-1:0] Y
);

    logic [SYNC-1:0]  sync_reg;
    logic             rfd_s;
    state_t           state_reg, state_next;
    logic             dav_reg, dav_next;
    logic [W-1:0]     x_reg, x_next;
    logic [W-1:0]     y_reg, y_next;
    logic [7:0]       sent_reg, sent_next;
    logic             overflow_reg;
    logic             pop;
    logic [2*W-1:0]   head;

    fifo_punti #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (load),
        .pop   (pop),
        .din   ({x_in, y_in}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // rfd comes from the consumer's clock domain; only rfd_s is trusted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_reg <= '0;
        else       sync_reg <= {sync_reg[SYNC-2:0], rfd};
    end
    assign rfd_s = sync_reg[SYNC-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            dav_reg      <= DAV_INATTIVO;
            x_reg        <= '0;
            y_reg        <= '0;
            sent_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dav_reg      <= dav_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            sent_reg     <= sent_next;
            overflow_reg <= load && full;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (!empty && rfd_s) state_next = S_SETUP;
            S_SETUP:   state_next = S_VALID;
            S_VALID:   if (!rfd_s) state_next = S_RELEASE;
            S_RELEASE: if (rfd_s) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // X,Y are only ever reloaded on IDLE->SETUP, so they stay put while dav_ is low.
    always_comb begin
        pop       = 1'b0;
        x_next    = x_reg;
        y_next    = y_reg;
        sent_next = sent_reg;
        dav_next  = (state_next == S_VALID) ? DAV_ATTIVO : DAV_INATTIVO;
        if (state_reg == S_IDLE && state_next == S_SETUP) begin
            pop              = 1'b1;
            {x_next, y_next} = head;
        end
        if (state_reg == S_RELEASE && state_next == S_IDLE)
            sent_next = sent_reg + 8'd1;
    end

    assign dav_     = dav_reg;
    assign X        = x_reg;
    assign Y        = y_reg;
    assign sent     = sent_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_trasmettitore_punti.sv
// Self-checking bench for trasmettitore_punti: fill/overflow table, hand-made
// latency and reset sequences, and a randomized run against a consumer model.
module tb_trasmettitore_punti;

    localparam int W        = 3;
    localparam int DEPTH    = 4;
    localparam int SYNC     = 2;
    localparam int N_RANDOM = 260;

    logic         clock = 1'b0;
    logic         cclk  = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] x_in, y_in;
    logic         full, empty, overflow;
    logic [7:0]   sent;
    logic         rfd;
    logic         dav_;
    logic [W-1:0] X, Y;

    logic rfd_tb   = 1'b0;
    logic rfd_cons = 1'b1;
    logic cons_en  = 1'b0;
    assign rfd = cons_en ? rfd_cons : rfd_tb;

    always #2 clock = ~clock;
    always #5 cclk  = ~cclk;

    trasmettitore_punti #(.W(W), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .x_in     (x_in),
        .y_in     (y_in),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .sent     (sent),
        .rfd      (rfd),
        .dav_     (dav_),
        .X        (X),
        .Y        (Y)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } point_t;

    point_t exp_q[$];
    int     recv   = 0;
    int     pushed = 0;

    typedef struct {
        logic         ld;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         full;
        logic         empty;
        logic         ovf;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Consumer model on its own slower clock: take the point when dav_ is low,
    // drop rfd, and raise it again once dav_ has gone back high.
    initial begin
        point_t p;
        forever begin
            @(posedge cclk);
            if (cons_en) begin
                if (rfd_cons && dav_ === 1'b0) begin
                    check("rx_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        p = exp_q.pop_front();
                        check("rx_x", X, p.x);
                        check("rx_y", Y, p.y);
                    end
                    recv++;
                    rfd_cons = 1'b0;
                end else if (!rfd_cons && dav_ === 1'b1) begin
                    rfd_cons = 1'b1;
                end
            end
        end
    end

    // X,Y must not move while dav_ stays low.
    logic         mon_dav = 1'b1;
    logic [W-1:0] mon_x, mon_y;
    initial begin
        forever begin
            @(negedge clock);
            if (mon_dav === 1'b0 && dav_ === 1'b0) begin
                check("stable_x", X, mon_x);
                check("stable_y", Y, mon_y);
            end
            mon_dav = dav_;
            mon_x   = X;
            mon_y   = Y;
        end
    end

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        x_in  = '0;
        y_in  = '0;

        tbl[0] = '{1'b1, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 3'd3, 3'd4, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 3'd1, 3'd1, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 3'd2, 3'd2, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (2) step();
        check("rst_dav", dav_, 1);
        check("rst_x", X, 0);
        check("rst_y", Y, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_overflow", overflow, 0);
        check("rst_sent", sent, 0);
        reset = 1'b0;
        repeat (3) step();

        // Fill and overflow with the consumer busy
        for (int i = 0; i < 8; i++) begin
            load = tbl[i].ld;
            x_in = tbl[i].x;
            y_in = tbl[i].y;
            step();
            check($sformatf("tbl%0d_full", i), full, tbl[i].full);
            check($sformatf("tbl%0d_empty", i), empty, tbl[i].empty);
            check($sformatf("tbl%0d_overflow", i), overflow, tbl[i].ovf);
            check($sformatf("tbl%0d_dav", i), dav_, 1);
        end
        load = 1'b0;

        // Drain: only the first four points go out
        exp_q.push_back('{3'd1, 3'd2});
        exp_q.push_back('{3'd3, 3'd4});
        exp_q.push_back('{3'd5, 3'd6});
        exp_q.push_back('{3'd7, 3'd7});
        recv     = 0;
        rfd_cons = 1'b1;
        cons_en  = 1'b1;
        for (int i = 0; i < 2000 && sent != 8'd4; i++) step();
        check("drain_sent", sent, 4);
        check("drain_recv", recv, 4);
        check("drain_empty", empty, 1);
        rfd_tb  = 1'b1;
        cons_en = 1'b0;

        // Single-point latency with rfd already synchronised high
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        load = 1'b1; x_in = 3'd7; y_in = 3'd1;
        step();
        load = 1'b0;
        check("lat_n_x", X, 0);
        check("lat_n_dav", dav_, 1);
        step();
        check("lat_n1_x", X, 7);
        check("lat_n1_y", Y, 1);
        check("lat_n1_dav", dav_, 1);
        step();
        check("lat_n2_dav", dav_, 0);
        rfd_tb = 1'b0;
        repeat (SYNC) step();
        check("rel_early_dav", dav_, 0);
        step();
        check("rel_dav", dav_, 1);
        rfd_tb = 1'b1;
        repeat (SYNC) step();
        check("ret_early_sent", sent, 0);
        step();
        check("ret_sent", sent, 1);
        check("ret_empty", empty, 1);

        // Push and pop on the same edge
        rfd_tb = 1'b0;
        repeat (3) step();
        load = 1'b1; x_in = 3'd1; y_in = 3'd2;
        step();
        load   = 1'b0;
        rfd_tb = 1'b1;
        check("pp_one_empty", empty, 0);
        repeat (2) step();
        load = 1'b1; x_in = 3'd3; y_in = 3'd4;
        step();
        load = 1'b0;
        check("pp_full", full, 0);
        check("pp_empty", empty, 0);
        check("pp_x", X, 1);
        check("pp_y", Y, 2);
        step();
        check("pp_dav", dav_, 0);
        check("pp_still_one", empty, 0);
        exp_q.delete();
        exp_q.push_back('{3'd1, 3'd2});
        exp_q.push_back('{3'd3, 3'd4});
        recv     = 0;
        rfd_cons = 1'b1;
        cons_en  = 1'b1;
        for (int i = 0; i < 2000 && sent != 8'd3; i++) step();
        check("pp_sent", sent, 3);
        check("pp_recv", recv, 2);
        check("pp_drained", empty, 1);
        rfd_tb  = 1'b1;
        cons_en = 1'b0;

        // Asynchronous reset while dav_ is asserted
        repeat (3) step();
        load = 1'b1; x_in = 3'd5; y_in = 3'd5;
        step();
        load = 1'b0;
        repeat (2) step();
        check("mid_valid_dav", dav_, 0);
        reset = 1'b1;
        #1;
        check("arst_dav", dav_, 1);
        check("arst_x", X, 0);
        check("arst_y", Y, 0);
        check("arst_empty", empty, 1);
        check("arst_sent", sent, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("post_rst_dav%0d", i), dav_, 1);
        end
        check("post_rst_sent", sent, 0);

        // Randomized run across the sent wrap
        exp_q.delete();
        recv     = 0;
        pushed   = 0;
        rfd_cons = 1'b1;
        cons_en  = 1'b1;
        for (int cyc = 0; cyc < 40000 && !(recv == N_RANDOM && pushed == N_RANDOM); cyc++) begin
            load = 1'b0;
            if (pushed < N_RANDOM && (pushed - recv) < DEPTH && $urandom_range(0, 1) == 1) begin
                x_in = W'($urandom);
                y_in = W'($urandom);
                load = 1'b1;
                exp_q.push_back('{x_in, y_in});
                pushed++;
            end
            step();
        end
        load = 1'b0;
        for (int i = 0; i < 200 && sent != 8'(N_RANDOM % 256); i++) step();
        check("rand_recv", recv, N_RANDOM);
        check("rand_sent_wrap", sent, N_RANDOM % 256);
        check("rand_queue_left", exp_q.size(), 0);
        check("rand_empty", empty, 1);
        check("rand_overflow", overflow, 0);
        cons_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
